l2norm_stream_arbiter: RTL and testbench
========================================

Name: l2norm_stream_arbiter

Overview:
Shares one L2-norm AXI-Stream engine between NUM_REQ packet sources. Packets are granted whole, in round-robin order: the grant locks from the first beat until the tlast beat. The block records the owner of every packet sent to the engine in a small in-order tag FIFO and routes each engine result back to that requester. It sits between the per-channel vector producers and the single norm engine instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 64, input beat width (engine io_in_tdata)
RES_W, 32, result width (engine io_out_tdata)
MAX_OUTSTANDING, 2, tag FIFO depth = max packets in engine without a returned result (power of 2, >=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
s_tdata  in  NUM_REQ*DATA_W  requester beats; requester i occupies bits [i*DATA_W +: DATA_W]
s_tvalid  in  NUM_REQ  per-requester valid
s_tlast  in  NUM_REQ  per-requester end of vector
s_tready  out  NUM_REQ  per-requester ready
m_tdata  out  DATA_W  to engine io_in_tdata
m_tvalid  out  1  to engine io_in_tvalid
m_tlast  out  1  to engine io_in_tlast
m_tready  in  1  from engine io_in_tready
r_tdata  in  RES_W  from engine io_out_tdata
r_tvalid  in  1  from engine io_out_tvalid
r_tready  out  1  to engine io_out_tready
o_tdata  out  RES_W  result broadcast to all requesters
o_tvalid  out  NUM_REQ  per-requester result valid
o_tready  in  NUM_REQ  per-requester result ready
grant_id  out  $clog2(NUM_REQ)  current/last granted requester
busy  out  1  high in GRANT state or when tag FIFO is non-empty
orphan_err  out  1  sticky flag: r_tvalid seen while tag FIFO empty

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), tag FIFO empty, orphan_err=0, grant_id=0. All s_tready, m_tvalid, o_tvalid and r_tready are 0. Reset mid-packet abandons the packet and its tag. The engine must be reset in the same cycle.
- FSM IDLE:
  - If any s_tvalid is high and the tag FIFO is not full, choose the first requester with s_tvalid high, searching last_grant+1, +2, ... with wrap modulo NUM_REQ.
  - Register the winner into grant_id, push grant_id into the tag FIFO, and go to GRANT.
  - If the tag FIFO is full, stay in IDLE. This is the backpressure point.
  - In IDLE, m_tvalid=0 and all s_tready=0.
- FSM GRANT, with g = grant_id:
  - m_tdata=s_tdata[g], m_tvalid=s_tvalid[g], m_tlast=s_tlast[g].
  - s_tready[g]=m_tready; all other s_tready=0. This path is purely combinational.
  - On the handshake (s_tvalid[g] && m_tready && s_tlast[g]): set last_grant=g and go to IDLE.
  - Each packet costs one IDLE bubble cycle; the grant is never preempted.
- Result routing:
  - head = tag FIFO output.
  - o_tdata=r_tdata.
  - o_tvalid[head] = r_tvalid && !empty; all other o_tvalid bits are 0.
  - r_tready = o_tready[head] && !empty.
  - Pop the tag FIFO on the handshake r_tvalid && r_tready.
- Empty tag FIFO:
  - r_tready=0 and all o_tvalid=0.
  - If r_tvalid is high, orphan_err is set and held until reset.
- Simultaneous push and pop in one cycle: both take effect and occupancy is unchanged. A push is never issued when full, because the full check happens before the grant.
- Packet of one beat: a tlast beat on the first transfer returns to IDLE on the next cycle.
- Requester deasserting s_tvalid mid-packet: the grant is held and m_tvalid follows s_tvalid[g].
- Latency: the first beat can transfer on the cycle after s_tvalid is first seen in IDLE.

Test Plan:
1. Single requester: req1 sends 3 beats (data 3, 4, 0; tlast on beat 3); the engine returns 5. Expect a grant the cycle after valid, m_tdata to match each beat, o_tvalid=4'b0010 with o_tdata=5, and the FIFO empty afterwards.
2. Round-robin: all 4 requesters hold 2-beat packets from reset. Expect grant order 0,1,2,3,0 and exactly one bubble between packets. s_tready is never high on two requesters at once.
3. Outstanding limit: the engine delays results 50 cycles while req0 and req2 each send a packet. Expect the third packet (req3) to stay ungranted with s_tready=0 until the first result pops. Results route to req0 first, then req2.
4. Result backpressure: o_tready[2]=0 for 10 cycles while r_tvalid=1 and head=2. Expect r_tready=0 and o_tdata stable, then a pop on the cycle o_tready[2] goes high.
5. Orphan: r_tvalid=1 with the FIFO empty. Expect orphan_err=1 on the next cycle, held until reset, and r_tready=0.
6. Reset mid-packet: reset=0 during beat 2 of a 4-beat packet. Expect all outputs idle and busy=0. After release, req0 wins first even if other requesters are also valid.

Source files
------------

// File: rtl/l2norm_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : l2norm_stream_arbiter
// Brief   : Whole-packet round-robin sharing of one L2-norm engine; an in-order
//           tag FIFO routes each engine result back to its packet's owner.
// Revision: 1.0
// ============================================================================
module l2norm_stream_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int DATA_W          = 64,
   parameter int RES_W           = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ*DATA_W-1:0]  s_tdata,
   input  logic [NUM_REQ-1:0]         s_tvalid,
   input  logic [NUM_REQ-1:0]         s_tlast,
   output logic [NUM_REQ-1:0]         s_tready,
   output logic [DATA_W-1:0]          m_tdata,
   output logic                       m_tvalid,
   output logic                       m_tlast,
   input  logic                       m_tready,
   input  logic [RES_W-1:0]           r_tdata,
   input  logic                       r_tvalid,
   output logic                       r_tready,
   output logic [RES_W-1:0]           o_tdata,
   output logic [NUM_REQ-1:0]         o_tvalid,
   input  logic [NUM_REQ-1:0]         o_tready,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       orphan_err
);

   localparam int c_gnt_w = $clog2(NUM_REQ);
   localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t             state_q;
   logic [c_gnt_w-1:0] grant_q;
   logic [c_gnt_w-1:0] last_q;
   logic [c_gnt_w-1:0] tag_q [MAX_OUTSTANDING];
   logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_cnt_w-1:0] count_q, count_d;
   logic               orphan_q;

   logic [DATA_W-1:0]  w_beat [NUM_REQ];
   logic               w_win_found;
   logic [c_gnt_w-1:0] w_win_id;
   logic               w_empty, w_full, w_push, w_pop, w_last_beat, w_granted;
   logic [c_gnt_w-1:0] w_head;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_beat[gi] = s_tdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin search starting just after the previous owner.
   always_comb begin
      logic [c_gnt_w-1:0] idx;
      idx         = '0;
      w_win_found = 1'b0;
      w_win_id    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = c_gnt_w'((int'(last_q) + k) % NUM_REQ);
         if (!w_win_found && s_tvalid[idx]) begin
            w_win_found = 1'b1;
            w_win_id    = idx;
         end
      end
   end

   assign w_granted   = (state_q == S_GRANT);
   assign w_empty     = (count_q == '0);
   assign w_full      = (count_q == c_cnt_w'(MAX_OUTSTANDING));
   assign w_push      = (state_q == S_IDLE) && w_win_found && !w_full;
   assign w_head      = tag_q[rd_ptr_q];
   assign w_pop       = r_tvalid && r_tready;
   assign w_last_beat = w_granted && s_tvalid[grant_q] && s_tlast[grant_q] && m_tready;

   assign m_tdata  = w_beat[grant_q];
   assign m_tvalid = w_granted && s_tvalid[grant_q];
   assign m_tlast  = w_granted && s_tlast[grant_q];

   always_comb begin
      s_tready = '0;
      if (w_granted) s_tready[grant_q] = m_tready;
   end

   assign o_tdata  = r_tdata;
   assign r_tready = o_tready[w_head] && !w_empty;

   always_comb begin
      o_tvalid = '0;
      if (r_tvalid && !w_empty) o_tvalid[w_head] = 1'b1;
   end

   assign busy       = w_granted || !w_empty;
   assign grant_id   = grant_q;
   assign orphan_err = orphan_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push)
         wr_ptr_d = (wr_ptr_q == c_ptr_w'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + c_ptr_w'(1);
      if (w_pop)
         rd_ptr_d = (rd_ptr_q == c_ptr_w'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + c_ptr_w'(1);
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + c_cnt_w'(1);
         2'b01:   count_d = count_q - c_cnt_w'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         last_q   <= c_gnt_w'(NUM_REQ - 1);
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         orphan_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (r_tvalid && w_empty) orphan_q <= 1'b1;
         if (w_push) tag_q[wr_ptr_q] <= w_win_id;
         case (state_q)
            S_IDLE: begin
               if (w_push) begin
                  grant_q <= w_win_id;
                  state_q <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (w_last_beat) begin
                  last_q  <= grant_q;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_l2norm_stream_arbiter.sv
`default_nettype none
// Bench for l2norm_stream_arbiter: queue-driven sources, a delayed integer-sqrt
// engine model, and per-requester expected-result queues.
module tb_l2norm_stream_arbiter;

   localparam int NUM_REQ         = 4;
   localparam int DATA_W          = 64;
   localparam int RES_W           = 32;
   localparam int MAX_OUTSTANDING = 2;
   localparam int GW              = $clog2(NUM_REQ);

   typedef struct { logic [DATA_W-1:0] data; logic last; } beat_t;
   typedef struct { logic [RES_W-1:0] data; int due; } res_t;
   typedef struct { int id; int cyc; } log_t;

   logic                      clock;
   logic                      reset;
   logic [DATA_W-1:0]         src_data [NUM_REQ];
   logic [NUM_REQ*DATA_W-1:0] s_tdata;
   logic [NUM_REQ-1:0]        s_tvalid, s_tlast, s_tready;
   logic [DATA_W-1:0]         m_tdata;
   logic                      m_tvalid, m_tlast, m_tready;
   logic [RES_W-1:0]          r_tdata, o_tdata;
   logic                      r_tvalid, r_tready;
   logic [NUM_REQ-1:0]        o_tvalid, o_tready;
   logic [GW-1:0]             grant_id;
   logic                      busy, orphan_err;

   int               errors = 0;
   int               checks = 0;
   int               cyc    = 0;
   int               eng_delay;
   logic             force_orphan;
   beat_t            src   [NUM_REQ][$];
   logic [RES_W-1:0] exp_q [NUM_REQ][$];
   res_t             rq[$];
   log_t             glog[$];
   log_t             rlog[$];

   assign s_tdata = {src_data[3], src_data[2], src_data[1], src_data[0]};

   l2norm_stream_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) dut (
      .clock(clock), .reset(reset),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tready(r_tready),
      .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .grant_id(grant_id), .busy(busy), .orphan_err(orphan_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned isqrt(input longint unsigned v);
      longint unsigned r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   function automatic bit sb_empty();
      for (int i = 0; i < NUM_REQ; i++)
         if (exp_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #3;
   endtask

   task automatic load_pkt(input int req, input logic [DATA_W-1:0] d0, d1, d2, d3, input int n);
      logic [DATA_W-1:0] d [4];
      longint unsigned   ss = 0;
      d = '{d0, d1, d2, d3};
      for (int b = 0; b < n; b++) begin
         src[req].push_back('{d[b], b == n - 1});
         ss = ss + d[b] * d[b];
      end
      exp_q[req].push_back(RES_W'(isqrt(ss)));
   endtask

   task automatic reset_assert();
      reset = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         src[i].delete();
         exp_q[i].delete();
      end
      glog.delete();
      rlog.delete();
      tick(2);
   endtask

   task automatic wait_done(input string tag, input int grants, input int budget);
      int n = 0;
      while (!(glog.size() >= grants && sb_empty()) && n < budget) begin
         tick(1);
         n++;
      end
      check(tag, 64'(n < budget), 64'(1));
   endtask

   // Sources, engine model and output monitor share one cycle loop.
   initial begin : bfm
      logic [NUM_REQ-1:0] took;
      logic               beat_ok, res_ok, blast, sop;
      logic [DATA_W-1:0]  bdata;
      longint unsigned    acc;
      acc = 0;
      sop = 1'b1;
      s_tvalid = '0;
      s_tlast  = '0;
      for (int i = 0; i < NUM_REQ; i++) src_data[i] = '0;
      r_tvalid = 1'b0;
      r_tdata  = '0;
      forever begin
         @(negedge clock);
         took    = s_tvalid & s_tready & {NUM_REQ{reset}};
         beat_ok = m_tvalid && m_tready && reset;
         res_ok  = r_tvalid && r_tready && reset;
         bdata   = m_tdata;
         blast   = m_tlast;
         if (reset) begin
            check("s_tready_onehot", 64'($countones(s_tready) <= 1), 64'(1));
            if (beat_ok && sop) glog.push_back('{int'(grant_id), cyc});
            if (beat_ok) sop = blast;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (o_tvalid[i[GW-1:0]] && o_tready[i[GW-1:0]]) begin
                  if (exp_q[i].size() == 0)
                     check("result_unexpected", 64'(i), 64'(NUM_REQ));
                  else
                     check("result_data", 64'(o_tdata), 64'(exp_q[i].pop_front()));
                  rlog.push_back('{i, cyc});
               end
            end
         end
         @(posedge clock);
         #1;
         cyc++;
         if (!reset) begin
            acc = 0;
            sop = 1'b1;
            rq.delete();
         end else begin
            for (int i = 0; i < NUM_REQ; i++)
               if (took[i[GW-1:0]] && src[i].size() > 0) src[i].delete(0);
            if (beat_ok) begin
               acc = acc + bdata * bdata;
               if (blast) begin
                  rq.push_back('{RES_W'(isqrt(acc)), cyc + eng_delay});
                  acc = 0;
               end
            end
            if (res_ok && rq.size() > 0) rq.delete(0);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (src[i].size() > 0) begin
               s_tvalid[i[GW-1:0]] = 1'b1;
               s_tlast[i[GW-1:0]]  = src[i][0].last;
               src_data[i]         = src[i][0].data;
            end else begin
               s_tvalid[i[GW-1:0]] = 1'b0;
               s_tlast[i[GW-1:0]]  = 1'b0;
               src_data[i]         = '0;
            end
         end
         r_tvalid = force_orphan || (rq.size() > 0 && cyc >= rq[0].due);
         r_tdata  = (rq.size() > 0) ? rq[0].data : '0;
      end
   end

   initial begin : main
      int n;
      reset        = 1'b0;
      o_tready     = '1;
      m_tready     = 1'b1;
      force_orphan = 1'b0;
      eng_delay    = 0;

      // Reset state
      reset_assert();
      check("rst_s_tready", 64'(s_tready), 64'(0));
      check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_o_tvalid", 64'(o_tvalid), 64'(0));
      check("rst_r_tready", 64'(r_tready), 64'(0));
      check("rst_grant_id", 64'(grant_id), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_orphan", 64'(orphan_err), 64'(0));
      reset = 1'b1;
      tick(1);

      // Single requester, 3 beats, result 5
      load_pkt(1, 3, 4, 0, 0, 3);
      tick(1);
      check("t1_idle_m_tvalid", 64'(m_tvalid), 64'(0));
      check("t1_idle_s_tready", 64'(s_tready), 64'(0));
      tick(1);
      check("t1_grant_id", 64'(grant_id), 64'(1));
      check("t1_busy", 64'(busy), 64'(1));
      check("t1_s_tready", 64'(s_tready), 64'(4'b0010));
      check("t1_beat0", 64'(m_tdata), 64'(3));
      check("t1_beat0_last", 64'(m_tlast), 64'(0));
      tick(1);
      check("t1_beat1", 64'(m_tdata), 64'(4));
      tick(1);
      check("t1_beat2", 64'(m_tdata), 64'(0));
      check("t1_beat2_last", 64'(m_tlast), 64'(1));
      tick(1);
      check("t1_m_tvalid_bubble", 64'(m_tvalid), 64'(0));
      check("t1_o_tvalid", 64'(o_tvalid), 64'(4'b0010));
      check("t1_o_tdata", 64'(o_tdata), 64'(5));
      check("t1_r_tready", 64'(r_tready), 64'(1));
      tick(1);
      check("t1_empty_after", 64'(busy), 64'(0));
      check("t1_result_count", 64'(rlog.size()), 64'(1));

      // Round-robin from reset: 0,1,2,3,0 with one bubble per packet
      reset_assert();
      load_pkt(0, 3, 4, 0, 0, 2);
      load_pkt(0, 0, 7, 0, 0, 2);
      load_pkt(1, 6, 8, 0, 0, 2);
      load_pkt(2, 5, 12, 0, 0, 2);
      load_pkt(3, 8, 15, 0, 0, 2);
      reset = 1'b1;
      wait_done("t2_done", 5, 300);
      check("t2_grant0", 64'(glog[0].id), 64'(0));
      check("t2_grant1", 64'(glog[1].id), 64'(1));
      check("t2_grant2", 64'(glog[2].id), 64'(2));
      check("t2_grant3", 64'(glog[3].id), 64'(3));
      check("t2_grant4", 64'(glog[4].id), 64'(0));
      for (int k = 1; k < 5; k++)
         check("t2_packet_spacing", 64'(glog[k].cyc - glog[k-1].cyc), 64'(3));

      // Outstanding limit: third packet waits for the first result
      reset_assert();
      eng_delay = 50;
      load_pkt(0, 3, 4, 0, 0, 2);
      load_pkt(2, 6, 8, 0, 0, 2);
      load_pkt(3, 5, 12, 0, 0, 2);
      reset = 1'b1;
      tick(20);
      check("t3_grants_while_full", 64'(glog.size()), 64'(2));
      check("t3_s_tready_blocked", 64'(s_tready), 64'(0));
      check("t3_m_tvalid_blocked", 64'(m_tvalid), 64'(0));
      check("t3_busy", 64'(busy), 64'(1));
      wait_done("t3_done", 3, 400);
      check("t3_result0_owner", 64'(rlog[0].id), 64'(0));
      check("t3_result1_owner", 64'(rlog[1].id), 64'(2));
      check("t3_result2_owner", 64'(rlog[2].id), 64'(3));
      check("t3_grant2_id", 64'(glog[2].id), 64'(3));
      check("t3_grant_after_pop", 64'(glog[2].cyc > rlog[0].cyc), 64'(1));
      eng_delay = 0;

      // Result backpressure on requester 2
      reset_assert();
      o_tready = 4'b1011;
      load_pkt(2, 6, 8, 0, 0, 2);
      reset = 1'b1;
      n = 0;
      while (!r_tvalid && n < 50) begin
         tick(1);
         n++;
      end
      check("t4_result_arrives", 64'(n < 50), 64'(1));
      for (int k = 0; k < 10; k++) begin
         check("t4_r_tready_held", 64'(r_tready), 64'(0));
         check("t4_o_tvalid", 64'(o_tvalid), 64'(4'b0100));
         check("t4_o_tdata_stable", 64'(o_tdata), 64'(10));
         tick(1);
      end
      o_tready = 4'b1111;
      #1;
      check("t4_r_tready_release", 64'(r_tready), 64'(1));
      tick(1);
      check("t4_popped", 64'(busy), 64'(0));
      check("t4_result_count", 64'(rlog.size()), 64'(1));
      check("t4_sb_empty", 64'(exp_q[2].size()), 64'(0));

      // Orphan result with empty tag FIFO
      reset_assert();
      reset = 1'b1;
      tick(1);
      force_orphan = 1'b1;
      tick(1);
      check("t5_orphan_not_yet", 64'(orphan_err), 64'(0));
      check("t5_r_tready", 64'(r_tready), 64'(0));
      check("t5_o_tvalid", 64'(o_tvalid), 64'(0));
      tick(1);
      check("t5_orphan_set", 64'(orphan_err), 64'(1));
      force_orphan = 1'b0;
      tick(3);
      check("t5_orphan_sticky", 64'(orphan_err), 64'(1));
      check("t5_r_tready_after", 64'(r_tready), 64'(0));
      reset_assert();
      check("t5_orphan_cleared", 64'(orphan_err), 64'(0));
      reset = 1'b1;
      tick(1);

      // Reset during beat 2 of a 4-beat packet
      load_pkt(2, 1, 2, 3, 4, 4);
      n = 0;
      while (!(m_tvalid && m_tdata == 2) && n < 50) begin
         tick(1);
         n++;
      end
      check("t6_reach_beat2", 64'(n < 50), 64'(1));
      reset_assert();
      check("t6_s_tready", 64'(s_tready), 64'(0));
      check("t6_m_tvalid", 64'(m_tvalid), 64'(0));
      check("t6_o_tvalid", 64'(o_tvalid), 64'(0));
      check("t6_r_tready", 64'(r_tready), 64'(0));
      check("t6_busy", 64'(busy), 64'(0));
      check("t6_grant_id", 64'(grant_id), 64'(0));
      load_pkt(1, 3, 4, 0, 0, 2);
      load_pkt(3, 6, 8, 0, 0, 2);
      load_pkt(0, 5, 12, 0, 0, 2);
      reset = 1'b1;
      wait_done("t6_done", 3, 300);
      check("t6_first_grant", 64'(glog[0].id), 64'(0));
      check("t6_second_grant", 64'(glog[1].id), 64'(1));
      check("t6_third_grant", 64'(glog[2].id), 64'(3));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
